// File: rtl/mem_access_unit.sv
// Memory-stage data access unit: word-addressed data memory with a fixed access
// latency, holding the pipeline (Ready=0) while an access is in flight.
module mem_access_unit #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] Mem_Res,
  output logic        Ready,
  output logic        Addr_Err
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_cnt;
  logic [3:0]    w_next_cnt;
  logic          w_commit;
  logic          w_req;
  logic [31:0]   w_offset;
  logic [31:0]   w_index;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_mem_res;
  logic          r_addr_err;

  assign w_req      = MEM_R_EN | MEM_W_EN;
  // Addresses below BASE_ADDR wrap to a huge index and fall out of range.
  assign w_offset   = ALU_Res - 32'(BASE_ADDR);
  assign w_index    = w_offset >> 2;
  assign w_in_range = (w_index < 32'(DEPTH));
  assign w_idx      = w_index[AW-1:0];

  assign Mem_Res  = r_mem_res;
  assign Addr_Err = r_addr_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next state, busy counter, commit strobe and the combinational Ready.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_commit     = 1'b0;
    Ready        = 1'b0;
    case (r_state)
      IDLE: begin
        Ready = ~w_req;
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = DONE;
            w_commit     = 1'b1;
          end else begin
            w_next_state = BUSY;
            w_next_cnt   = CNT_INIT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next_state = DONE;
          w_commit     = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        Ready        = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Store-both-enables counts as a store, so Mem_Res is only touched by pure loads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mem_res  <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_commit & ~w_in_range;
      if (w_commit && MEM_R_EN && !MEM_W_EN) begin
        r_mem_res <= w_in_range ? r_mem[w_idx] : 32'd0;
      end else begin
        r_mem_res <= r_mem_res;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_commit && MEM_W_EN && w_in_range) begin
      r_mem[w_idx] <= Val_Rm;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expectations are queued at request time
// and compared when Ready rises on the DONE cycle.
module tb_mem_access_unit;
  parameter int WAIT_CYCLES = 2;
  localparam int DEPTH     = 64;
  localparam int BASE_ADDR = 1024;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [31:0] Mem_Res;
  logic        Ready;
  logic        Addr_Err;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_res;
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res),
    .Val_Rm(Val_Rm),
    .Mem_Res(Mem_Res),
    .Ready(Ready),
    .Addr_Err(Addr_Err)
  );

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    model_res = 32'd0;
  endtask

  task automatic model_push(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
    logic [31:0] idx;
    logic        inr;
    exp_t        e;
    idx = (addr - 32'(BASE_ADDR)) >> 2;
    inr = (idx < 32'(DEPTH));
    if (wr) begin
      if (inr) model_mem[int'(idx)] = data;
    end else if (rd) begin
      model_res = inr ? model_mem[int'(idx)] : 32'd0;
    end
    e.res = model_res;
    e.err = ~inr;
    sb_q.push_back(e);
  endtask

  // Drives one access from the IDLE negedge; returns at the negedge after DONE.
  task automatic drive_access(input string name, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    logic [31:0] prev_res;
    int          zeros;
    bit          done;
    prev_res = model_res;
    model_push(rd, wr, addr, data);
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    ALU_Res  = addr;
    Val_Rm   = data;
    zeros = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (i == 0) begin
        n_checks++;
        if (Mem_Res !== prev_res) begin
          n_fails++;
          $display("FAIL %s hold_before: Mem_Res=%h expected %h", name, Mem_Res, prev_res);
        end
      end
      if (Ready === 1'b1) done = 1'b1;
      else begin
        zeros++;
        @(negedge CLK);
      end
    end
    n_checks++;
    if (!done) begin
      n_fails++;
      $display("FAIL %s timeout: Ready never rose, got %0d low cycles expected %0d",
               name, zeros, WAIT_CYCLES + 1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end else begin
      if (zeros !== WAIT_CYCLES + 1) begin
        n_fails++;
        $display("FAIL %s ready_low: got %0d cycles expected %0d", name, zeros, WAIT_CYCLES + 1);
      end
      e = sb_q.pop_front();
      n_checks++;
      if (Mem_Res !== e.res) begin
        n_fails++;
        $display("FAIL %s mem_res: got %h expected %h", name, Mem_Res, e.res);
      end
      n_checks++;
      if (Addr_Err !== e.err) begin
        n_fails++;
        $display("FAIL %s addr_err: got %b expected %b", name, Addr_Err, e.err);
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle_cycles(input string name, input int n);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      n_checks++;
      if (Ready !== 1'b1 || Addr_Err !== 1'b0 || Mem_Res !== model_res) begin
        n_fails++;
        $display("FAIL %s idle: Ready=%b Addr_Err=%b Mem_Res=%h expected 1 0 %h",
                 name, Ready, Addr_Err, Mem_Res, model_res);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res = 32'd0;
    Val_Rm = 32'd0;
    model_clear();
    @(negedge CLK);
    #1;
    n_checks++;
    if (Ready !== 1'b1 || Mem_Res !== 32'd0 || Addr_Err !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: Ready=%b Mem_Res=%h Addr_Err=%b expected 1 0 0",
               Ready, Mem_Res, Addr_Err);
    end
    @(negedge CLK);
    RST = 1'b0;
    idle_cycles("reset_idle", 4);
  endtask

  task automatic test_store_load();
    drive_access("st_1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    drive_access("ld_1028", 1'b1, 1'b0, 32'd1028, 32'd0);
    idle_cycles("post_ld", 1);
    drive_access("ld_1031", 1'b1, 1'b0, 32'd1031, 32'd0);
    idle_cycles("post_ld_1031", 1);
  endtask

  task automatic test_back_to_back();
    drive_access("b2b_st", 1'b0, 1'b1, 32'd1024, 32'd5);
    drive_access("b2b_ld", 1'b1, 1'b0, 32'd1024, 32'd0);
    idle_cycles("b2b_idle", 2);
  endtask

  task automatic test_out_of_range();
    drive_access("ld_1020", 1'b1, 1'b0, 32'd1020, 32'd0);
    idle_cycles("oor_idle1", 1);
    drive_access("ld_top", 1'b1, 1'b0, 32'(BASE_ADDR + 4 * DEPTH), 32'd0);
    idle_cycles("oor_idle2", 1);
    drive_access("st_1020", 1'b0, 1'b1, 32'd1020, 32'h12345678);
    drive_access("ld_last", 1'b1, 1'b0, 32'(BASE_ADDR + 4 * (DEPTH - 1)), 32'd0);
    drive_access("ld_w0", 1'b1, 1'b0, 32'd1024, 32'd0);
    drive_access("ld_w1", 1'b1, 1'b0, 32'd1028, 32'd0);
    idle_cycles("oor_idle3", 1);
  endtask

  task automatic test_both_enables();
    drive_access("both_st", 1'b1, 1'b1, 32'd1032, 32'd7);
    idle_cycles("both_idle", 1);
    drive_access("both_ld", 1'b1, 1'b0, 32'd1032, 32'd0);
    idle_cycles("both_idle2", 1);
  endtask

  task automatic test_reset_mid_access();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b1;
    ALU_Res  = 32'd1036;
    Val_Rm   = 32'd9;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (Mem_Res !== 32'd0 || Addr_Err !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_mid state: Mem_Res=%h Addr_Err=%b expected 0 0", Mem_Res, Addr_Err);
    end
    MEM_W_EN = 1'b0;
    #1;
    n_checks++;
    if (Ready !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_mid ready: got %b expected 1", Ready);
    end
    model_clear();
    @(negedge CLK);
    RST = 1'b0;
    idle_cycles("rst_mid_idle", 1);
    drive_access("ld_1036", 1'b1, 1'b0, 32'd1036, 32'd0);
    drive_access("ld_1028_clr", 1'b1, 1'b0, 32'd1028, 32'd0);
    idle_cycles("end_idle", 2);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_out_of_range();
    test_both_enables();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
